// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared constants and types for the instruction fetch unit.
//   PcWidthDef   - default fetch address width
//   InstWidthDef - default instruction word width
//   fetch_mode_e - effective fetch mode (normal, or draining stale responses)
package ifetch_unit_pkg;

    localparam int unsigned PcWidthDef   = 32;
    localparam int unsigned InstWidthDef = 32;

    typedef enum logic {
        ModeNormal = 1'b0,
        ModeDrain  = 1'b1
    } fetch_mode_e;

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// fetch_fifo: parameterised synchronous FIFO with a synchronous clear.
//   clk_i, rst_n_i  - clock, asynchronous active-low reset
//   clear_i         - drop all contents (wins over push/pop)
//   push_i, wdata_i - write one entry (legal when full only together with pop_i)
//   pop_i           - remove the head entry (ignored when empty)
//   rdata_o         - head entry (undefined when empty)
//   full_o, empty_o, count_o - occupancy
module fetch_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (push_i & ~clear_i) |-> (~full_o | pop_i));

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: issues in-order instruction memory requests for the fetch PC, pairs each
// variable-latency response with its PC and buffers the results for decode. Responses
// belonging to requests issued before a flush are discarded.
//   clk_i, rst_n_i        - clock, asynchronous active-low reset
//   F_PC_i                - fetch PC from the PC register
//   flush_i               - redirect/bubble, kills everything in flight
//   D_stall_i             - decode cannot accept this cycle
//   imem_req_valid_o/addr_o, imem_req_ready_i - request channel
//   imem_resp_valid_i/data_i                   - in-order response channel (no backpressure)
//   F_stall_o             - hold the PC register
//   D_valid_o, D_PC_o, D_instr_o               - instruction presented to decode
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = PcWidthDef,
    parameter int unsigned INST_WIDTH = InstWidthDef,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [PC_WIDTH-1:0]   F_PC_i,
    input  logic                  flush_i,
    input  logic                  D_stall_i,
    output logic                  imem_req_valid_o,
    output logic [PC_WIDTH-1:0]   imem_req_addr_o,
    input  logic                  imem_req_ready_i,
    input  logic                  imem_resp_valid_i,
    input  logic [INST_WIDTH-1:0] imem_resp_data_i,
    output logic                  F_stall_o,
    output logic                  D_valid_o,
    output logic [PC_WIDTH-1:0]   D_PC_o,
    output logic [INST_WIDTH-1:0] D_instr_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned ResW = PC_WIDTH + INST_WIDTH;

    logic [CntW-1:0]     outstanding_q, outstanding_d;
    logic [CntW-1:0]     discard_q, discard_d;
    fetch_mode_e         mode;

    logic                credits_ok, fire, resp_keep, res_pop;
    logic [PC_WIDTH-1:0] pcq_rdata;
    logic                pcq_full, pcq_empty;
    logic [CntW-1:0]     pcq_count;
    logic [ResW-1:0]     res_rdata;
    logic                res_full, res_empty;
    logic [CntW-1:0]     res_count;

    // Every outstanding request reserves a result slot, so the result FIFO never overflows.
    assign credits_ok = ({1'b0, outstanding_q} + {1'b0, res_count}) < (CntW+1)'(DEPTH);

    assign mode      = (discard_q != '0) ? ModeDrain : ModeNormal;
    assign fire      = imem_req_valid_o & imem_req_ready_i;
    assign resp_keep = imem_resp_valid_i & ~flush_i & (mode == ModeNormal);
    assign res_pop   = D_valid_o & ~D_stall_i;

    assign imem_req_valid_o = ~flush_i & credits_ok;
    assign imem_req_addr_o  = F_PC_i;
    // During a flush the PC register loads its redirect target instead of holding.
    assign F_stall_o        = ~fire & ~flush_i;

    always_comb begin
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (flush_i) begin
            // Everything still in flight after this edge is stale.
            outstanding_d = outstanding_q - CntW'(imem_resp_valid_i);
            discard_d     = outstanding_d;
        end else begin
            outstanding_d = outstanding_q + CntW'(fire) - CntW'(imem_resp_valid_i);
            if (imem_resp_valid_i && mode == ModeDrain) discard_d = discard_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .Width (PC_WIDTH),
        .Depth (DEPTH)
    ) u_pc_queue (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (flush_i),
        .push_i  (fire),
        .wdata_i (F_PC_i),
        .pop_i   (resp_keep),
        .rdata_o (pcq_rdata),
        .full_o  (pcq_full),
        .empty_o (pcq_empty),
        .count_o (pcq_count)
    );

    fetch_fifo #(
        .Width (ResW),
        .Depth (DEPTH)
    ) u_result_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (flush_i),
        .push_i  (resp_keep),
        .wdata_i ({pcq_rdata, imem_resp_data_i}),
        .pop_i   (res_pop),
        .rdata_o (res_rdata),
        .full_o  (res_full),
        .empty_o (res_empty),
        .count_o (res_count)
    );

    always_comb begin
        D_valid_o = ~res_empty;
        D_PC_o    = '0;
        D_instr_o = '0;
        if (!res_empty) begin
            D_PC_o    = res_rdata[ResW-1:INST_WIDTH];
            D_instr_o = res_rdata[INST_WIDTH-1:0];
        end
    end

    resp_needs_request_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        imem_resp_valid_i |-> (outstanding_q != '0));

    kept_resp_has_pc_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        resp_keep |-> ~pcq_empty);

    no_fire_when_pcq_full_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        fire |-> (~pcq_full | resp_keep));

    no_result_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        resp_keep |-> (~res_full | res_pop));

    // Every outstanding request is either a stale one being drained or has a queued PC.
    count_invariant_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        ({1'b0, outstanding_q} == ({1'b0, discard_q} + {1'b0, pcq_count})));

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    localparam int unsigned PW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [PW-1:0] F_PC_i;
    logic          flush_i;
    logic          D_stall_i;
    logic          imem_req_valid_o;
    logic [PW-1:0] imem_req_addr_o;
    logic          imem_req_ready_i;
    logic          imem_resp_valid_i;
    logic [IW-1:0] imem_resp_data_i;
    logic          F_stall_o;
    logic          D_valid_o;
    logic [PW-1:0] D_PC_o;
    logic [IW-1:0] D_instr_o;

    always #5 clk_i = ~clk_i;

    ifetch_unit #(
        .PC_WIDTH   (PW),
        .INST_WIDTH (IW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .F_PC_i            (F_PC_i),
        .flush_i           (flush_i),
        .D_stall_i         (D_stall_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .F_stall_o         (F_stall_o),
        .D_valid_o         (D_valid_o),
        .D_PC_o            (D_PC_o),
        .D_instr_o         (D_instr_o)
    );

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] addr;
    } mreq_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    mreq_t       mq[$];
    logic [31:0] got[$];
    logic [31:0] cyc = 0;
    logic [31:0] lat = 1;

    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        ready = 1'b1;
    logic [31:0] pc    = '0;

    logic        o_req_valid, o_fstall, o_dvalid, o_fire;
    logic [31:0] o_addr, o_dpc, o_dinstr;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock cycle: apply stimulus and the memory response at the falling edge, sample the
    // outputs 1 time unit later, then do the memory/PC bookkeeping for the coming rising edge.
    task automatic cycle();
        @(negedge clk_i);
        cyc++;
        rst_n_i          = rst_n;
        F_PC_i           = pc;
        flush_i          = flush;
        D_stall_i        = stall;
        imem_req_ready_i = ready;
        if (!rst_n) mq.delete();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid_i = 1'b1;
            imem_resp_data_i  = inst_of(mq[0].addr);
        end else begin
            imem_resp_valid_i = 1'b0;
            imem_resp_data_i  = '0;
        end
        #1;
        o_req_valid = imem_req_valid_o;
        o_addr      = imem_req_addr_o;
        o_fstall    = F_stall_o;
        o_dvalid    = D_valid_o;
        o_dpc       = D_PC_o;
        o_dinstr    = D_instr_o;
        o_fire      = rst_n & imem_req_valid_o & ready;
        if (imem_resp_valid_i) void'(mq.pop_front());
        if (o_fire) begin
            mq.push_back('{due: cyc + lat, addr: o_addr});
            pc = pc + 32'd4;
        end
        if (o_dvalid && !stall && !flush && rst_n) begin
            got.push_back(o_dpc);
            check_eq("pair", o_dinstr, inst_of(o_dpc));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        ready = 1'b1;
        pc    = '0;
        repeat (2) cycle();
        got.delete();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        ready = 1'b0;
        repeat (8) cycle();
    endtask

    initial begin
        rst_n_i           = 1'b0;
        F_PC_i            = '0;
        flush_i           = 1'b0;
        D_stall_i         = 1'b0;
        imem_req_ready_i  = 1'b1;
        imem_resp_valid_i = 1'b0;
        imem_resp_data_i  = '0;

        // Reset state, then streaming with latency 1 and decode always ready.
        lat = 1;
        rst_n = 1'b0;
        repeat (3) cycle();
        check_eq("rst_dvalid", o_dvalid, 0);
        check_eq("rst_dpc", o_dpc, 0);
        check_eq("rst_dinstr", o_dinstr, 0);
        check_eq("rst_outstanding", dut.outstanding_q, 0);
        rst_n = 1'b1;
        cycle();
        check_eq("s0_req_valid", o_req_valid, 1);
        check_eq("s0_addr", o_addr, 32'h0);
        check_eq("s0_fstall", o_fstall, 0);
        cycle();
        check_eq("s1_addr", o_addr, 32'h4);
        check_eq("s1_dvalid", o_dvalid, 0);
        cycle();
        check_eq("s2_dvalid", o_dvalid, 1);
        check_eq("s2_dpc", o_dpc, 32'h0);
        check_eq("s2_dinstr", o_dinstr, inst_of(32'h0));
        check_eq("s2_req_valid", o_req_valid, 0);
        check_eq("s2_fstall", o_fstall, 1);
        cycle();
        check_eq("s3_dpc", o_dpc, 32'h4);
        check_eq("s3_addr", o_addr, 32'h8);
        cycle();
        // DEPTH=2 credits leave a one-cycle hole here.
        check_eq("s4_dvalid", o_dvalid, 0);
        cycle();
        check_eq("s5_dpc", o_dpc, 32'h8);
        drain();
        check_eq("s_count", got.size(), 4);
        check_eq("s_last", got[3], 32'hC);

        // Decode backpressure for 5 cycles.
        do_reset();
        stall = 1'b1;
        repeat (2) cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("bp_req_valid", o_req_valid, 0);
            check_eq("bp_fstall", o_fstall, 1);
        end
        check_eq("bp_hold_dpc", o_dpc, 32'h0);
        stall = 1'b0;
        cycle();
        check_eq("bp_rel_dpc0", o_dpc, 32'h0);
        check_eq("bp_rel_req0", o_req_valid, 0);
        cycle();
        check_eq("bp_rel_dpc1", o_dpc, 32'h4);
        check_eq("bp_resume_req", o_req_valid, 1);
        check_eq("bp_resume_addr", o_addr, 32'h8);
        drain();
        check_eq("bp_count", got.size(), 3);
        check_eq("bp_last", got[2], 32'h8);

        // Flush with two requests outstanding, latency 3.
        do_reset();
        lat = 3;
        repeat (2) cycle();
        flush = 1'b1;
        pc    = 32'h100;
        cycle();
        check_eq("fl_req_valid", o_req_valid, 0);
        check_eq("fl_fstall", o_fstall, 0);
        flush = 1'b0;
        cycle();
        check_eq("fl_discard", dut.discard_q, 2);
        repeat (5) cycle();
        drain();
        check_eq("fl_count", got.size(), 2);
        check_eq("fl_first", got[0], 32'h100);
        check_eq("fl_second", got[1], 32'h104);

        // Flush in the same cycle as a response, two outstanding, latency 2.
        do_reset();
        lat = 2;
        repeat (2) cycle();
        flush = 1'b1;
        pc    = 32'h200;
        cycle();
        flush = 1'b0;
        cycle();
        check_eq("flr_discard", dut.discard_q, 1);
        repeat (3) cycle();
        drain();
        check_eq("flr_count", got.size(), 2);
        check_eq("flr_first", got[0], 32'h200);
        check_eq("flr_second", got[1], 32'h204);
        check_eq("flr_discard_end", dut.discard_q, 0);

        // Request ready toggling 1,0,0,1.
        do_reset();
        lat = 1;
        ready = 1'b1;
        cycle();
        check_eq("rdy0_fstall", o_fstall, 0);
        ready = 1'b0;
        cycle();
        check_eq("rdy1_fstall", o_fstall, 1);
        cycle();
        check_eq("rdy2_fstall", o_fstall, 1);
        ready = 1'b1;
        cycle();
        check_eq("rdy3_fstall", o_fstall, 0);
        check_eq("rdy3_addr", o_addr, 32'h4);
        drain();
        check_eq("rdy_count", got.size(), 2);
        check_eq("rdy_first", got[0], 32'h0);
        check_eq("rdy_second", got[1], 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
